// File: rtl/crc_tx_framer.sv
// rtl/crc_tx_framer.sv - TX framer that forwards payload bytes and appends a CRC-16 trailer
// Engine: CRC-16 x^16+x^15+x^2+1, MSB-first, one byte per clock, init 0xFFFF.

module crc16_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);
  logic [15:0] crc_next;

  always_comb begin
    logic fb;
    crc_next = crc_out;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = crc_next[15] ^ data_in[i];
      crc_next = {crc_next[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_out <= 16'hFFFF;
    else if (crc_en) crc_out <= crc_next;
  end
endmodule

module crc_tx_framer #(
  parameter int          MAX_LEN       = 1024,
  parameter bit          CRC_MSB_FIRST = 1'b1,
  parameter logic [15:0] XOR_OUT       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] frame_len,
  output logic        err_oversize,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, DATA, CRC_HI, CRC_LO, CLEAR, DROP} state_t;

  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);

  state_t      state;
  logic [15:0] cnt;
  logic        clr_q;
  logic        drop_pending;
  logic [15:0] crc_out;
  logic [15:0] crc_x;
  logic [7:0]  crc_first;
  logic [7:0]  crc_second;
  logic        slot_free;
  logic        in_data;
  logic        crc_en;
  logic        eng_rst;

  assign slot_free  = !m_valid || m_ready;
  assign in_data    = (state == IDLE) || (state == DATA);
  assign s_ready    = !rst && ((in_data && slot_free) || (state == DROP));
  assign crc_en     = s_valid && s_ready && in_data;
  assign busy       = (state != IDLE);
  assign crc_x      = crc_out ^ XOR_OUT;
  assign crc_first  = CRC_MSB_FIRST ? crc_x[15:8] : crc_x[7:0];
  assign crc_second = CRC_MSB_FIRST ? crc_x[7:0]  : crc_x[15:8];

  // clr_q comes straight from a flop, so ORing it into the engine reset cannot glitch
  assign eng_rst = rst | clr_q;

  crc16_engine u_engine (
    .clk     (clk),
    .rst     (eng_rst),
    .crc_en  (crc_en),
    .data_in (s_data),
    .crc_out (crc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      clr_q        <= 1'b0;
      drop_pending <= 1'b0;
      m_data       <= 8'd0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      frame_len    <= 16'd0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= 1'b0;
      if (m_ready) m_valid <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (s_valid && s_ready) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            cnt     <= cnt + 16'd1;
            state   <= DATA;
            if (s_last) begin
              state <= CRC_HI;
            end else if (cnt + 16'd1 == MAX_LEN_C) begin
              err_oversize <= 1'b1;
              drop_pending <= 1'b1;
              state        <= CRC_HI;
            end
          end
        end
        CRC_HI: begin
          if (slot_free) begin
            m_data  <= crc_first;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            state   <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (slot_free) begin
            m_data    <= crc_second;
            m_valid   <= 1'b1;
            m_last    <= 1'b1;
            frame_len <= cnt;
            cnt       <= 16'd0;
            clr_q     <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          clr_q        <= 1'b0;
          drop_pending <= 1'b0;
          state        <= drop_pending ? DROP : IDLE;
        end
        DROP: begin
          if (s_valid && s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_tx_framer.sv
// tb/tb_crc_tx_framer.sv - directed self-checking bench for crc_tx_framer
// dut0 uses default parameters; dut1 uses MAX_LEN=4, low-byte-first, XOR_OUT=0xFFFF.

module tb_crc_tx_framer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       m_ready;
  logic       sel;
  logic       rnd_ready;

  logic        s_ready0, m_valid0, m_last0, err0, busy0;
  logic [7:0]  m_data0;
  logic [15:0] frame_len0;
  logic        s_ready1, m_valid1, m_last1, err1, busy1;
  logic [7:0]  m_data1;
  logic [15:0] frame_len1;

  logic        s_ready_m, m_valid_m, m_last_m, err_m, busy_m;
  logic [7:0]  m_data_m;
  logic [15:0] frame_len_m;

  int n_assert = 0;
  int n_fail   = 0;
  int rd       = 0;
  int err_cycles = 0;
  logic [7:0] out_d[$];
  logic       out_l[$];
  logic [7:0] pl[$];

  always #5 clk = ~clk;

  crc_tx_framer dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && !sel), .s_last(s_last),
    .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0),
    .m_ready(m_ready), .frame_len(frame_len0), .err_oversize(err0), .busy(busy0)
  );

  crc_tx_framer #(.MAX_LEN(4), .CRC_MSB_FIRST(1'b0), .XOR_OUT(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid && sel), .s_last(s_last),
    .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1),
    .m_ready(m_ready), .frame_len(frame_len1), .err_oversize(err1), .busy(busy1)
  );

  assign s_ready_m   = sel ? s_ready1   : s_ready0;
  assign m_valid_m   = sel ? m_valid1   : m_valid0;
  assign m_last_m    = sel ? m_last1    : m_last0;
  assign m_data_m    = sel ? m_data1    : m_data0;
  assign err_m       = sel ? err1       : err0;
  assign busy_m      = sel ? busy1      : busy0;
  assign frame_len_m = sel ? frame_len1 : frame_len0;

  always @(negedge clk) begin
    if (m_valid_m && m_ready) begin
      out_d.push_back(m_data_m);
      out_l.push_back(m_last_m);
    end
    if (err_m) err_cycles++;
  end

  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[i][k];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_data = d; s_valid = 1'b1; s_last = l;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      if (s_ready_m) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  // Compares the next payload+trailer in the capture queue against the model
  task automatic check_frame(input string tag, input bit msb_first, input logic [15:0] xo);
    int n;
    logic [15:0] c;
    n = pl.size() + 2;
    for (int t = 0; t < 2000 && out_d.size() < rd + n; t++) tick();
    chk({tag, "_complete"}, 32'(out_d.size() >= rd + n), 32'd1);
    c = crc_model(pl) ^ xo;
    if (out_d.size() >= rd + n) begin
      for (int i = 0; i < pl.size(); i++) begin
        chk($sformatf("%s_pay%0d", tag, i), {24'd0, out_d[rd + i]}, {24'd0, pl[i]});
        chk($sformatf("%s_paylast%0d", tag, i), 32'(out_l[rd + i]), 32'd0);
      end
      chk({tag, "_crc1"}, {24'd0, out_d[rd + n - 2]}, {24'd0, msb_first ? c[15:8] : c[7:0]});
      chk({tag, "_crc1last"}, 32'(out_l[rd + n - 2]), 32'd0);
      chk({tag, "_crc2"}, {24'd0, out_d[rd + n - 1]}, {24'd0, msb_first ? c[7:0] : c[15:8]});
      chk({tag, "_crc2last"}, 32'(out_l[rd + n - 1]), 32'd1);
    end
    rd = rd + n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1; sel = 1'b0; rnd_ready = 1'b0;
    tick(); tick();
    chk("rst_s_ready", 32'(s_ready_m), 32'd0);
    chk("rst_m_valid", 32'(m_valid_m), 32'd0);
    chk("rst_m_last", 32'(m_last_m), 32'd0);
    chk("rst_m_data", {24'd0, m_data_m}, 32'd0);
    chk("rst_frame_len", {16'd0, frame_len_m}, 32'd0);
    chk("rst_err", 32'(err_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", 32'(s_ready_m), 32'd1);

    // single-byte frame {0x00}: 0x00, 0xFD, 0x02
    send(8'h00, 1'b1);
    chk("t1_busy_hi", 32'(busy_m), 32'd1);
    chk("t1_sready_hi", 32'(s_ready_m), 32'd0);
    chk("t1_data_hi", {24'd0, m_data_m}, 32'h00);
    tick();
    chk("t1_busy_lo", 32'(busy_m), 32'd1);
    chk("t1_data_lo", {24'd0, m_data_m}, 32'hFD);
    tick();
    chk("t1_busy_clr", 32'(busy_m), 32'd1);
    chk("t1_data_clr", {24'd0, m_data_m}, 32'h02);
    chk("t1_last_clr", 32'(m_last_m), 32'd1);
    chk("t1_frame_len", {16'd0, frame_len_m}, 32'd1);
    tick();
    chk("t1_busy_idle", 32'(busy_m), 32'd0);
    chk("t1_valid_idle", 32'(m_valid_m), 32'd0);
    pl.delete(); pl.push_back(8'h00);
    check_frame("t1", 1'b1, 16'h0000);

    // back-to-back {0x00} frames: engine must be re-seeded in between
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    check_frame("t2a", 1'b1, 16'h0000);
    check_frame("t2b", 1'b1, 16'h0000);
    chk("t2b_hand_crc1", {24'd0, out_d[rd - 2]}, 32'hFD);
    chk("t2b_hand_crc2", {24'd0, out_d[rd - 1]}, 32'h02);

    // 64 random bytes under random backpressure
    rnd_ready = 1'b1;
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom_range(255, 0)));
    for (int i = 0; i < 64; i++) send(pl[i], i == 63);
    check_frame("t3", 1'b1, 16'h0000);
    rnd_ready = 1'b0; m_ready = 1'b1;
    tick(); tick(); tick();
    chk("t3_frame_len", {16'd0, frame_len_m}, 32'd64);
    chk("t3_no_extra", 32'(out_d.size()), 32'(rd));

    // backpressure hold, then reset mid-frame
    m_ready = 1'b0;
    send(8'h11, 1'b0);
    @(negedge clk);
    chk("t5_sready_full", 32'(s_ready_m), 32'd0);
    tick(); tick();
    chk("t5_hold_data", {24'd0, m_data_m}, 32'h11);
    chk("t5_hold_valid", 32'(m_valid_m), 32'd1);
    m_ready = 1'b1;
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(m_valid_m), 32'd0);
    chk("t5_rst_busy", 32'(busy_m), 32'd0);
    chk("t5_rst_sready", 32'(s_ready_m), 32'd0);
    chk("t5_rst_data", {24'd0, m_data_m}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rd = out_d.size();
    send(8'h00, 1'b1);
    pl.delete(); pl.push_back(8'h00);
    check_frame("t5", 1'b1, 16'h0000);
    tick(); tick();
    chk("t5_frame_len", {16'd0, frame_len_m}, 32'd1);

    // second instance: low byte first, XOR_OUT=0xFFFF
    sel = 1'b1;
    tick();
    send(8'h00, 1'b1);
    check_frame("t6", 1'b0, 16'hFFFF);
    chk("t6_hand_crc1", {24'd0, out_d[rd - 2]}, 32'hFD);
    chk("t6_hand_crc2", {24'd0, out_d[rd - 1]}, 32'h02);

    // oversize: 6-byte frame truncated at 4
    err_cycles = 0;
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    pl.delete();
    for (int i = 1; i <= 4; i++) pl.push_back(8'(i));
    check_frame("t4", 1'b0, 16'hFFFF);
    tick(); tick(); tick();
    chk("t4_err_pulse", 32'(err_cycles), 32'd1);
    chk("t4_frame_len", {16'd0, frame_len_m}, 32'd4);
    chk("t4_no_extra", 32'(out_d.size()), 32'(rd));
    chk("t4_idle", 32'(busy_m), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
